// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, instruction size, reset NOP encoding,
// redirect alignment mask and a small misalignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Wide enough for any XLEN we build; callers slice [XLEN-1:0].
    localparam logic [63:0] ALIGN_MASK  = ~64'h3;

    // A redirect target is misaligned when either of its byte-offset bits is set.
    function automatic logic low_bits_set(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and IF->ID handoff bundle.
// Latency: n/a (wires only).
// Backpressure: imem_gnt_i accepts a request; id_ready_i accepts an instruction.
//
// master: fetch sequencer side; slave: memory + decode side.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            id_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );
endinterface

// File: rtl/fetch_ctrl_timer.sv
// Response watchdog: counts cycles spent waiting for an instruction response.
// Latency: expire_o is combinational in the LIMIT-th running cycle.
// Backpressure: none; run_i gates counting, clr_i restarts from zero.
//
// Ports: clk_i, rst_n, clr_i (hold at zero), run_i (count this cycle),
// expire_o (limit reached while running).
module fetch_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int          CW   = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    // The counter holds LIMIT-1 on the expiring cycle, so the first running
    // cycle counts as one and the pulse lands on the LIMIT-th.
    assign expire_o = run_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (run_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: picks next PC, issues one imem request at a time, hands one instruction to decode.
// Latency: gnt at N, rvalid at N+k, inst_valid_o at N+k+1; at best one instruction per 3 cycles.
// Backpressure: stall_i holds requests off; inst held until id_ready_i; redirects override both.
//
// Ports: clk_i/rst_n; pc_cur_i in, pc_next_o/pc_write_o to the PC register;
// fb (fetch_ctrl_if.master) carries the imem handshake and the decode handoff;
// stall_i, branch_taken_i/branch_target_i, trap_i/trap_vector_i redirect inputs;
// misalign_o and fetch_err_o one-cycle status pulses.
// Optional build macro FETCH_TIMEOUT_EN adds a response watchdog (fetch_timer).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            rst_n,
    input  logic            clk_i,
    input  logic [XLEN-1:0] pc_cur_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_write_o,
    fetch_ctrl_if.master    fb,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            misalign_o,
    output logic            fetch_err_o
);

    fetch_state_e    state_q, state_d;
    logic            drop_q, drop_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            misalign_q;

    logic            redirect;
    logic [XLEN-1:0] redir_target;
    logic            req;
    logic            pc_write;
    logic            timeout_hit;

    assign redirect     = trap_i | branch_taken_i;
    assign redir_target = trap_i ? trap_vector_i : branch_target_i;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        req_pc_d     = req_pc_q;
        req          = 1'b0;
        pc_write     = redirect;
        pc_next_o    = redirect ? (redir_target & ALIGN_MASK[XLEN-1:0])
                                : (pc_cur_i + XLEN'(INSTR_BYTES));

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end

            REQ: begin
                req = ~stall_i & ~redirect;
                if (req && fb.imem_gnt_i) begin
                    pc_write = 1'b1;
                    req_pc_d = pc_cur_i;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (fb.imem_rvalid_i) begin
                    // A redirect in the same cycle makes this response stale too.
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d       = fb.imem_rdata_i;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = OUT;
                    end
                end else if (redirect || timeout_hit) begin
                    // Stay until the outstanding response drains, then drop it.
                    drop_d = 1'b1;
                end
            end

            OUT: begin
                // Squash and accept both free the slot; the result is the same.
                if (redirect || fb.id_ready_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INSTR;
            inst_pc_q    <= '0;
            req_pc_q     <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_pc_q     <= req_pc_d;
            misalign_q   <= redirect & low_bits_set(redir_target[1:0]);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic fetch_err_q;

    // Counting pauses once the response is already marked stale, and a
    // response arriving on the limit cycle is taken rather than timed out.
    fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clr_i    (state_q != WAIT),
        .run_i    ((state_q == WAIT) && !drop_q && !fb.imem_rvalid_i),
        .expire_o (timeout_hit)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= timeout_hit;
        end
    end

    assign fetch_err_o = fetch_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign fetch_err_o        = 1'b0;
`endif

    // Reset gates the PC write so a redirect seen during reset cannot move the PC.
    assign pc_write_o      = pc_write & rst_n;
    assign fb.imem_req_o   = req;
    assign fb.imem_addr_o  = pc_cur_i;
    assign fb.inst_valid_o = inst_valid_q;
    assign fb.inst_o       = inst_q;
    assign fb.inst_pc_o    = inst_pc_q;
    assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    localparam int XLEN = 32;
    localparam int TO   = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_reg = '0;
    logic [31:0] pc_next_o;
    logic        pc_write_o;
    logic        stall_i = 0, branch_taken_i = 0, trap_i = 0;
    logic [31:0] branch_target_i = '0, trap_vector_i = '0;
    logic        misalign_o, fetch_err_o;

    always #5 clk_i = ~clk_i;

    fetch_ctrl_if #(.XLEN(XLEN)) fb ();

    fetch_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .rst_n           (rst_n),
        .clk_i           (clk_i),
        .pc_cur_i        (pc_reg),
        .pc_next_o       (pc_next_o),
        .pc_write_o      (pc_write_o),
        .fb              (fb),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .trap_i          (trap_i),
        .trap_vector_i   (trap_vector_i),
        .misalign_o      (misalign_o),
        .fetch_err_o     (fetch_err_o)
    );

    typedef struct {
        bit          trap;
        logic [31:0] tv;
        bit          br;
        logic [31:0] bt;
        bit          stall, gnt, rv;
        logic [31:0] rdata;
        bit          idr;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e_req, e_pcw;
        logic [31:0] e_pcn;
        bit          e_iv;
        logic [31:0] e_ipc;
        bit          e_mis;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } held_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: booted flag, one outstanding fetch, stale flag,
    // a one-deep queue of instructions waiting for decode.
    bit          m_booted, m_out, m_discard, m_mis, m_err;
    int          m_age;
    logic [31:0] m_fpc;
    held_t       held[$];

    logic        obs_req, obs_pcw, obs_iv, obs_mis, obs_err;
    logic [31:0] obs_pcn, obs_ipc, obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 0; m_out = 0; m_discard = 0; m_mis = 0; m_err = 0;
        m_age = 0; m_fpc = '0; held.delete(); pc_reg = '0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model after posedge.
    task automatic step(input stim_t s);
        bit          redir, e_req, e_pcw, new_err;
        logic [31:0] tgt, e_pcn;
        trap_i = s.trap; trap_vector_i = s.tv; branch_taken_i = s.br; branch_target_i = s.bt;
        stall_i = s.stall; fb.imem_gnt_i = s.gnt; fb.imem_rvalid_i = s.rv;
        fb.imem_rdata_i = s.rdata; fb.id_ready_i = s.idr;
        redir = s.trap || s.br;
        tgt   = s.trap ? s.tv : s.bt;
        e_req = m_booted && !m_out && held.size() == 0 && !s.stall && !redir;
        e_pcw = redir || (e_req && s.gnt);
        e_pcn = redir ? {tgt[31:2], 2'b00} : pc_reg + 32'd4;
        @(negedge clk_i);
        obs_req = fb.imem_req_o; obs_pcw = pc_write_o; obs_pcn = pc_next_o;
        obs_iv = fb.inst_valid_o; obs_ipc = fb.inst_pc_o; obs_mis = misalign_o;
        obs_err = fetch_err_o; obs_addr = fb.imem_addr_o;
        chk("m_req", obs_req, e_req);
        chk("m_pcw", obs_pcw, e_pcw);
        chk("m_addr", obs_addr, pc_reg);
        if (e_pcw) chk("m_pcnext", obs_pcn, e_pcn);
        chk("m_ivalid", obs_iv, held.size() != 0);
        if (held.size() != 0) begin
            chk("m_inst", fb.inst_o, held[0].inst);
            chk("m_ipc", obs_ipc, held[0].pc);
        end
        chk("m_misalign", obs_mis, m_mis);
        chk("m_fetch_err", obs_err, m_err);
        @(posedge clk_i);
        #1;
        new_err = 0;
        if (m_out) begin
            if (s.rv) begin
                m_out = 0;
                if (!m_discard && !redir) held.push_back('{inst: s.rdata, pc: m_fpc});
                m_discard = 0;
            end else begin
                m_age++;
                if (TO_EN && !m_discard && m_age == TO) begin
                    m_discard = 1;
                    new_err   = 1;
                end
                if (redir) m_discard = 1;
            end
        end else if (held.size() != 0 && (redir || s.idr)) begin
            void'(held.pop_front());
        end
        if (e_req && s.gnt) begin
            m_out = 1; m_fpc = pc_reg; m_age = 0;
        end
        m_booted = 1;
        m_mis    = redir && (tgt[1:0] != 2'b00);
        m_err    = new_err;
        if (e_pcw) pc_reg = e_pcn;
    endtask

    function automatic vec_t mk(bit trap, logic [31:0] tv, bit br, logic [31:0] bt,
                                bit stall, bit gnt, bit rv, logic [31:0] rdata, bit idr,
                                bit e_req, bit e_pcw, logic [31:0] e_pcn, bit e_iv,
                                logic [31:0] e_ipc, bit e_mis, logic [31:0] e_addr);
        vec_t v;
        v.s = '{trap: trap, tv: tv, br: br, bt: bt, stall: stall, gnt: gnt,
                rv: rv, rdata: rdata, idr: idr};
        v.e_req = e_req; v.e_pcw = e_pcw; v.e_pcn = e_pcn; v.e_iv = e_iv;
        v.e_ipc = e_ipc; v.e_mis = e_mis; v.e_addr = e_addr;
        return v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{trap: 0, tv: 0, br: 0, bt: 0, stall: 0, gnt: 0, rv: 0, rdata: 0, idr: 0};
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        stim_t s;
        int    rv_wait;
        bit    was_out;

        // Reset: redirect and grant are ignored while rst_n is low.
        fb.imem_gnt_i = 1; fb.imem_rvalid_i = 0; fb.imem_rdata_i = '0; fb.id_ready_i = 1;
        trap_i = 1; trap_vector_i = 32'h44;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", fb.imem_req_o, 0);
        chk("rst_pcw", pc_write_o, 0);
        chk("rst_ivalid", fb.inst_valid_o, 0);
        chk("rst_inst", fb.inst_o, 32'h0000_0013);
        chk("rst_ipc", fb.inst_pc_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_fetch_err", fetch_err_o, 0);
        trap_i = 0;
        rst_n  = 1;

        //          trap tv      br bt          st gn rv rdata         idr  req pcw pcn          iv ipc          mis addr
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   0, 0, 0,            0, 0,           0, 0));
        tbl.push_back(mk(0, 0,    0, 0,          0, 1, 0, 0,            0,   1, 1, 4,            0, 0,           0, 0));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 1, 32'h00500093, 0,   0, 0, 0,            0, 0,           0, 4));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            1,   0, 0, 0,            1, 0,           0, 4));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0,         1, 1, 0, 0,            0,   0, 0, 0,            0, 0,           0, 4));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   1, 0, 0,            0, 0,           0, 4));
        tbl.push_back(mk(0, 0,    0, 0,          0, 1, 0, 0,            0,   1, 1, 8,            0, 0,           0, 4));
        tbl.push_back(mk(0, 0,    1, 32'h100,    0, 0, 0, 0,            0,   0, 1, 32'h100,      0, 0,           0, 8));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 1, 32'hdeadbeef, 0,   0, 0, 0,            0, 0,           0, 32'h100));
        tbl.push_back(mk(0, 0,    0, 0,          0, 1, 0, 0,            0,   1, 1, 32'h104,      0, 0,           0, 32'h100));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 1, 32'h00a00113, 0,   0, 0, 0,            0, 0,           0, 32'h104));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   0, 0, 0,            1, 32'h100,     0, 32'h104));
        tbl.push_back(mk(1, 32'h80, 1, 32'h200,  0, 0, 0, 0,            1,   0, 1, 32'h80,       1, 32'h100,     0, 32'h104));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   1, 0, 0,            0, 0,           0, 32'h80));
        tbl.push_back(mk(0, 0,    1, 32'h102,    0, 0, 0, 0,            0,   0, 1, 32'h100,      0, 0,           0, 32'h80));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   1, 0, 0,            0, 0,           1, 32'h100));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   1, 0, 0,            0, 0,           0, 32'h100));
        tbl.push_back(mk(0, 0,    1, 32'hFFFFFFFC, 0, 0, 0, 0,          0,   0, 1, 32'hFFFFFFFC, 0, 0,           0, 32'h100));
        tbl.push_back(mk(0, 0,    0, 0,          0, 1, 0, 0,            0,   1, 1, 0,            0, 0,           0, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 1, 32'h13,       0,   0, 0, 0,            0, 0,           0, 0));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            1,   0, 0, 0,            1, 32'hFFFFFFFC, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0,          0, 0, 0, 0,            0,   1, 0, 0,            0, 0,           0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].s);
            chk($sformatf("t%0d_req", i), obs_req, tbl[i].e_req);
            chk($sformatf("t%0d_pcw", i), obs_pcw, tbl[i].e_pcw);
            if (tbl[i].e_pcw) chk($sformatf("t%0d_pcnext", i), obs_pcn, tbl[i].e_pcn);
            chk($sformatf("t%0d_ivalid", i), obs_iv, tbl[i].e_iv);
            if (tbl[i].e_iv) chk($sformatf("t%0d_ipc", i), obs_ipc, tbl[i].e_ipc);
            chk($sformatf("t%0d_misalign", i), obs_mis, tbl[i].e_mis);
            chk($sformatf("t%0d_addr", i), obs_addr, tbl[i].e_addr);
        end

        // Response watchdog: no rvalid for TO cycles, then a late response.
        s = idle(); s.gnt = 1;
        step(s);
        chk("to_issue_pcw", obs_pcw, 1);
        for (int i = 1; i <= TO; i++) begin
            step(idle());
            chk($sformatf("to_w%0d_err", i), obs_err, 0);
        end
        step(idle());
        chk("to_err_pulse", obs_err, TO_EN);
        s = idle(); s.rv = 1; s.rdata = 32'h00100073;
        step(s);
        chk("to_late_err", obs_err, 0);
        s = idle(); s.idr = 1;
        step(s);
        chk("to_late_ivalid", obs_iv, !TO_EN);

        // Randomised traffic against the model.
        rv_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            s.trap  = ($urandom % 20) == 0;
            s.tv    = $urandom;
            s.br    = ($urandom % 8) == 0;
            s.bt    = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.stall = ($urandom % 4) == 0;
            s.gnt   = $urandom % 2;
            s.rv    = m_out && rv_wait == 1;
            s.rdata = $urandom;
            s.idr   = $urandom % 2;
            was_out = m_out;
            step(s);
            if (rv_wait > 0) rv_wait--;
            if (!was_out && m_out) rv_wait = $urandom_range(1, 3);
        end

        // Asynchronous reset with a request outstanding.
        for (int i = 0; i < 20 && !m_out; i++) begin
            s = idle(); s.gnt = 1; s.idr = 1;
            step(s);
        end
        chk("mid_outstanding", m_out, 1);
        s = idle();
        trap_i = 0; branch_taken_i = 0; fb.imem_rvalid_i = 0; fb.imem_gnt_i = 0;
        rst_n = 0;
        #2;
        chk("mid_rst_req", fb.imem_req_o, 0);
        chk("mid_rst_ivalid", fb.inst_valid_o, 0);
        chk("mid_rst_inst", fb.inst_o, 32'h0000_0013);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n = 1;
        step(idle());
        s = idle(); s.gnt = 1;
        step(s);
        chk("post_rst_addr", obs_addr, 0);
        chk("post_rst_pcnext", obs_pcn, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the PC register's write port (PCWrite_i / pc_i) and drives the instruction-memory request handshake.
- Arbitrates next-PC sources: trap vector, branch/jump redirect, sequential PC+4.
- Honours hazard stalls, discards stale in-flight responses after a redirect, and presents one fetched instruction at a time to decode.
- Sits between the PC register, the instruction memory port and the IF/ID stage.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT_CYCLES, 255, response watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- rst_n  in  1  asynchronous, active-low reset.
- clk_i  in  1  clock.
- pc_cur_i  in  XLEN  current PC register output; this is the address of the next fetch.
- pc_next_o  out  XLEN  value to the PC register's pc_i.
- pc_write_o  out  1  to PCWrite_i.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address; always equals pc_cur_i.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  32  response instruction.
- stall_i  in  1  hazard stall from the hazard unit.
- branch_taken_i  in  1  EX-stage redirect.
- branch_target_i  in  XLEN  redirect target.
- trap_i  in  1  trap redirect.
- trap_vector_i  in  XLEN  trap target.
- id_ready_i  in  1  decode accepts the instruction.
- inst_valid_o  out  1  instruction valid to decode.
- inst_o  out  32  instruction.
- inst_pc_o  out  XLEN  PC of inst_o.
- misalign_o  out  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- fetch_err_o  out  1  one-cycle pulse on timeout (FETCH_TIMEOUT_EN only).

Behaviour:
- Reset clears state to BOOT, drop_q=0, inst_valid_o=0, inst_o=32'h00000013 (NOP), inst_pc_o=0, misalign_o=0, fetch_err_o=0.
- While in reset, imem_req_o=0 and pc_write_o=0.
- Redirect priority: trap_i > branch_taken_i > sequential.
- On any redirect cycle, in any state:
  - pc_write_o=1 and pc_next_o=target with bits[1:0] forced to 0.
  - imem_req_o is forced to 0 that cycle.
  - misalign_o is registered high for one cycle if the target's low bits were nonzero.
  - A redirect overrides stall_i.
- States:
  - BOOT: one cycle, no request, then REQ.
  - REQ: imem_req_o = ~stall_i & ~redirect. On gnt: pc_write_o=1, pc_next_o=pc_cur_i+4, latch inst_pc_q<=pc_cur_i, go to WAIT. With no gnt, stay with pc_write_o=0 and the address held stable.
  - WAIT: no new request (one outstanding maximum).
    - Redirect here: set drop_q.
    - On rvalid with drop_q=1: discard the response, clear drop_q, go to REQ.
    - On rvalid with drop_q=0: inst_o<=rdata, inst_pc_o<=inst_pc_q, inst_valid_o<=1, go to OUT.
    - If rvalid and a redirect arrive in the same cycle, the response is discarded.
  - OUT: inst_valid_o held with inst_o/inst_pc_o stable until id_ready_i.
    - On accept: inst_valid_o<=0, go to REQ.
    - On redirect: inst_valid_o<=0 (squash), go to REQ. Squash wins over a simultaneous accept.
- Latency: gnt at cycle N, rvalid at N+k (k≥1), inst_valid_o high at N+k+1.
- Throughput: one instruction per 3 cycles minimum. No pipelined fetching.
- PC+4 wraps modulo 2^XLEN (0xFFFFFFFC → 0).
- An asynchronous reset mid-transaction abandons the request. The memory side must not deliver rvalid after reset.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in WAIT and clears on entry.
  - On reaching TIMEOUT_CYCLES: fetch_err_o pulses one cycle, drop_q<=1, state stays in WAIT so a late response is discarded.
  - Next entry to REQ uses the already-advanced PC. The trap unit is expected to redirect.
  - The counter does not count while drop_q=1.
- Undefined: fetch_err_o tied 0; WAIT lasts indefinitely.

Decomposition:
- Package fetch_pkg:
  - state enum {BOOT, REQ, WAIT, OUT}.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h00000013.
  - ALIGN_MASK.
- One natural sub-module: fetch_timer (watchdog counter), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
1. Reset release with PC=0, gnt immediate, rvalid one cycle later with 0x00500093, id_ready_i=1 -> inst_valid_o high with inst_pc_o=0; pc_write_o with pc_next_o=4 at the gnt cycle; next request address 4.
2. stall_i=1 for 5 cycles in REQ -> imem_req_o=0 and pc_write_o=0 throughout; request resumes the cycle stall_i drops, address unchanged.
3. branch_taken_i with target 0x100 while in WAIT -> pc_next_o=0x100, pc_write_o=1; the following rvalid is discarded (inst_valid_o stays 0); the next request address is 0x100.
4. trap_i (vector 0x80) and branch_taken_i (0x200) in the same cycle during OUT -> pc_next_o=0x80, inst_valid_o cleared, next fetch at 0x80.
5. Branch target 0x102 -> misalign_o pulses one cycle, pc_next_o=0x100.
6. FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> fetch_err_o pulses 4 cycles after entering WAIT; a late rvalid is then discarded.
